// File: rtl/mem_dma_copy.sv
// -----------------------------------------------------------------------------
// mem_dma_copy
//
// Purpose:
//   Word-granular memory-to-memory copy engine. It acts as the initiator on a
//   single-port req/ready memory interface, usually port B of a dual-port BRAM
//   whose other port belongs to the CPU. A one-cycle start pulse loads source,
//   destination and word count. Each word is copied as one read followed by
//   one write, in strictly forward address order.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   cfg_start       one-cycle start pulse, samples cfg_src/cfg_dst/cfg_len
//   cfg_src/dst     4-byte aligned byte addresses
//   cfg_len         number of words to copy (0 = nothing to do)
//   cfg_abort       level-sampled request to stop early
//   busy            high while a read or write phase is active
//   done            one-cycle completion pulse (normal, error, empty or abort)
//   err             sticky misalignment flag, updated by each start in IDLE
//   aborted         sticky flag, last transfer was ended by abort
//   words_left      words not yet written
//   mem_*           req/ready memory initiator port
// -----------------------------------------------------------------------------
module mem_dma_copy #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_left,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [ADDR_W-1:0] r_srcPtr;
  logic [ADDR_W-1:0] r_dstPtr;
  logic [XLEN-1:0]   r_buf;
  logic [LEN_W-1:0]  r_wordsLeft;
  logic              r_err;
  logic              r_aborted;
  logic              r_abortPend;

  logic              w_active;
  logic              w_handshake;
  logic              w_misaligned;
  logic              w_lenZero;
  logic              w_abortSeen;
  logic              w_lastWord;

  // The handshake is derived from the state register rather than from the
  // mem_req output so the next-state logic has no combinational self-loop.
  // An abort counts if it is pending from an earlier cycle or present now.
  assign w_active     = (r_state == RD) || (r_state == WR);
  assign w_handshake  = w_active && mem_ready;
  assign w_misaligned = (cfg_src[1:0] != 2'b00) || (cfg_dst[1:0] != 2'b00);
  assign w_lenZero    = (cfg_len == '0);
  assign w_abortSeen  = r_abortPend || cfg_abort;
  assign w_lastWord   = (r_wordsLeft == LEN_W'(1));

  assign err        = r_err;
  assign aborted    = r_aborted;
  assign words_left = r_wordsLeft;

  // State register. Reset is asynchronous so mem_req, which is decoded from
  // the state, drops the moment rst_n goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. Memory outputs depend only on registered
  // state, so they stay stable for the whole of a stalled transaction. A
  // rejected or empty start still passes through DONE to produce the pulse.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          if (w_misaligned || w_lenZero) begin
            w_nextState = DONE;
          end else begin
            w_nextState = RD;
          end
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = r_srcPtr;
        if (w_handshake) begin
          w_nextState = w_abortSeen ? DONE : WR;
        end
      end
      WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_dstPtr;
        mem_wdata = r_buf;
        if (w_handshake) begin
          w_nextState = (w_lastWord || w_abortSeen) ? DONE : RD;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath. Any start seen in IDLE refreshes err and clears aborted; only
  // an aligned, non-empty start loads the pointers and count. An abort request
  // is remembered until the outstanding transaction completes. aborted is only
  // raised when words genuinely remain, so an abort that coincides with the
  // final write still reports a normal completion. Pointer increments wrap
  // naturally at the address width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srcPtr    <= '0;
      r_dstPtr    <= '0;
      r_buf       <= '0;
      r_wordsLeft <= '0;
      r_err       <= 1'b0;
      r_aborted   <= 1'b0;
      r_abortPend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_err       <= w_misaligned;
            r_aborted   <= 1'b0;
            r_abortPend <= 1'b0;
            if (!w_misaligned && !w_lenZero) begin
              r_srcPtr    <= cfg_src;
              r_dstPtr    <= cfg_dst;
              r_wordsLeft <= cfg_len;
            end
          end
        end
        RD: begin
          if (cfg_abort) begin
            r_abortPend <= 1'b1;
          end
          if (w_handshake) begin
            r_buf <= mem_rdata;
            if (w_abortSeen) begin
              r_aborted <= 1'b1;
            end
          end
        end
        WR: begin
          if (cfg_abort) begin
            r_abortPend <= 1'b1;
          end
          if (w_handshake) begin
            r_srcPtr    <= r_srcPtr + ADDR_W'(4);
            r_dstPtr    <= r_dstPtr + ADDR_W'(4);
            r_wordsLeft <= r_wordsLeft - LEN_W'(1);
            if (w_abortSeen && !w_lastWord) begin
              r_aborted <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
